// File: rtl/vc_control.sv
// vc_control: victim-cache controller that sequences lookup, swap, writeback and insert for L1 misses
module vc_control #(
    parameter int tag_width        = 24,
    parameter int vc_size          = 8,
    parameter int num_mux_sel_bits = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        l1_vc_req,
    input  logic [tag_width-1:0]        l1_vc_tag,
    input  logic                        l1_victim_valid,
    input  logic [tag_width-1:0]        l1_victim_tag,
    input  logic                        l1_victim_dirty,
    input  logic [num_mux_sel_bits-1:0] vc_datamux_sel,
    output logic                        vc_tag_cmp,
    output logic                        vc_tag_write,
    output logic [vc_size-1:0]          vc_tag_store_ld_mask,
    output logic [tag_width-1:0]        vc_tag_store_datain,
    output logic                        vc_data_write,
    output logic                        mem_wb_req,
    input  logic                        mem_wb_ack,
    output logic [num_mux_sel_bits-1:0] vc_wb_sel,
    output logic                        vc_l1_resp,
    output logic                        vc_l1_hit,
    output logic                        vc_busy
);
    localparam int pw = (vc_size > 1) ? $clog2(vc_size) : 1;

    typedef enum logic [2:0] {IDLE, CMP, SWAP, WB, INSERT, RESP} state_t;

    state_t state;
    logic [vc_size-1:0] valid, dirty;
    logic [pw-1:0] ptr, ptr_inc, idx, tgt, tgt_next, free_idx, sel_idx;
    logic [tag_width-1:0] vic_tag;
    logic vic_valid, vic_dirty, any_free, hit;

    function automatic logic [vc_size-1:0] onehot(input logic [pw-1:0] i);
        return {{(vc_size-1){1'b0}}, 1'b1} << i;
    endfunction

    assign sel_idx  = vc_datamux_sel[pw-1:0];
    assign hit      = (int'(vc_datamux_sel) < vc_size) && valid[sel_idx];
    assign ptr_inc  = (int'(ptr) == vc_size - 1) ? '0 : ptr + 1'b1;
    assign tgt_next = any_free ? free_idx : ptr;
    assign vc_busy  = state != IDLE;

    // Descending scan so the lowest-index invalid entry wins
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = vc_size - 1; i >= 0; i--)
            if (!valid[i]) begin
                free_idx = pw'(i);
                any_free = 1'b1;
            end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= IDLE;
            valid                <= '0;
            dirty                <= '0;
            ptr                  <= '0;
            idx                  <= '0;
            tgt                  <= '0;
            vic_tag              <= '0;
            vic_valid            <= 1'b0;
            vic_dirty            <= 1'b0;
            vc_tag_cmp           <= 1'b0;
            vc_tag_write         <= 1'b0;
            vc_data_write        <= 1'b0;
            vc_tag_store_ld_mask <= '0;
            vc_tag_store_datain  <= '0;
            mem_wb_req           <= 1'b0;
            vc_wb_sel            <= '0;
            vc_l1_resp           <= 1'b0;
            vc_l1_hit            <= 1'b0;
        end else begin
            vc_tag_cmp           <= 1'b0;
            vc_tag_write         <= 1'b0;
            vc_data_write        <= 1'b0;
            vc_tag_store_ld_mask <= '0;
            vc_tag_store_datain  <= '0;
            vc_l1_resp           <= 1'b0;
            vc_l1_hit            <= 1'b0;
            case (state)
                IDLE: if (l1_vc_req) begin
                    state               <= CMP;
                    vic_valid           <= l1_victim_valid;
                    vic_tag             <= l1_victim_tag;
                    vic_dirty           <= l1_victim_dirty;
                    vc_tag_cmp          <= 1'b1;
                    vc_tag_store_datain <= l1_vc_tag;
                end
                CMP: if (hit) begin
                    state <= SWAP;
                    idx   <= sel_idx;
                    if (vic_valid) begin
                        vc_tag_write         <= 1'b1;
                        vc_data_write        <= 1'b1;
                        vc_tag_store_ld_mask <= onehot(sel_idx);
                        vc_tag_store_datain  <= vic_tag;
                    end
                end else if (!vic_valid) begin
                    state      <= RESP;
                    vc_l1_resp <= 1'b1;
                end else begin
                    tgt <= tgt_next;
                    if (valid[tgt_next] && dirty[tgt_next]) begin
                        state      <= WB;
                        mem_wb_req <= 1'b1;
                        vc_wb_sel  <= num_mux_sel_bits'(tgt_next);
                    end else begin
                        state                <= INSERT;
                        vc_tag_write         <= 1'b1;
                        vc_data_write        <= 1'b1;
                        vc_tag_store_ld_mask <= onehot(tgt_next);
                        vc_tag_store_datain  <= vic_tag;
                    end
                end
                SWAP: begin
                    if (vic_valid) dirty[idx] <= vic_dirty;
                    else valid[idx] <= 1'b0;
                    state      <= RESP;
                    vc_l1_resp <= 1'b1;
                    vc_l1_hit  <= 1'b1;
                end
                WB: if (mem_wb_ack) begin
                    state                <= INSERT;
                    mem_wb_req           <= 1'b0;
                    vc_wb_sel            <= '0;
                    vc_tag_write         <= 1'b1;
                    vc_data_write        <= 1'b1;
                    vc_tag_store_ld_mask <= onehot(tgt);
                    vc_tag_store_datain  <= vic_tag;
                end
                INSERT: begin
                    valid[tgt] <= 1'b1;
                    dirty[tgt] <= vic_dirty;
                    if (valid[tgt]) ptr <= ptr_inc;
                    state      <= RESP;
                    vc_l1_resp <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vc_control.sv
// tb_vc_control: directed checks of lookup, swap, insert, writeback, wrap and reset behaviour
module tb_vc_control;
    logic clk = 1'b0, rst = 1'b0;
    logic l1_vc_req = 1'b0, l1_victim_valid = 1'b0, l1_victim_dirty = 1'b0, mem_wb_ack = 1'b0;
    logic [23:0] l1_vc_tag = '0, l1_victim_tag = '0, vc_tag_store_datain;
    logic [3:0] vc_datamux_sel = '0, vc_wb_sel;
    logic [7:0] vc_tag_store_ld_mask;
    logic vc_tag_cmp, vc_tag_write, vc_data_write, mem_wb_req, vc_l1_resp, vc_l1_hit, vc_busy;
    int checks = 0, passed = 0;
    int r_lat, r_wbc;
    logic r_hit, r_cmp, r_bad;
    logic [7:0] r_mask;
    logic [23:0] r_wtag, r_din;
    logic [3:0] r_wbs;
    logic [16:0] got;

    vc_control dut (
        .clk(clk), .rst(rst), .l1_vc_req(l1_vc_req), .l1_vc_tag(l1_vc_tag),
        .l1_victim_valid(l1_victim_valid), .l1_victim_tag(l1_victim_tag),
        .l1_victim_dirty(l1_victim_dirty), .vc_datamux_sel(vc_datamux_sel),
        .vc_tag_cmp(vc_tag_cmp), .vc_tag_write(vc_tag_write),
        .vc_tag_store_ld_mask(vc_tag_store_ld_mask), .vc_tag_store_datain(vc_tag_store_datain),
        .vc_data_write(vc_data_write), .mem_wb_req(mem_wb_req), .mem_wb_ack(mem_wb_ack),
        .vc_wb_sel(vc_wb_sel), .vc_l1_resp(vc_l1_resp), .vc_l1_hit(vc_l1_hit), .vc_busy(vc_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [52:0] all_outs();
        return {vc_tag_cmp, vc_tag_write, vc_tag_store_ld_mask, vc_tag_store_datain, vc_data_write,
                mem_wb_req, vc_wb_sel, vc_l1_resp, vc_l1_hit, vc_busy};
    endfunction

    // Issues one request and follows it to its response, acking a writeback in its ack_at-th cycle
    task automatic run_req(input logic [23:0] tag, input logic vv, input logic [23:0] vtag,
                           input logic vd, input logic [3:0] sel, input int ack_at);
        l1_vc_req = 1'b1; l1_vc_tag = tag; l1_victim_valid = vv;
        l1_victim_tag = vtag; l1_victim_dirty = vd; vc_datamux_sel = sel;
        tick();
        l1_vc_req = 1'b0;
        r_lat = 1; r_wbc = 0; r_mask = '0; r_wtag = '0; r_wbs = '0; r_bad = 1'b0;
        r_cmp = vc_tag_cmp; r_din = vc_tag_store_datain;
        while (!vc_l1_resp && r_lat < 100) begin
            if (vc_tag_write !== vc_data_write) r_bad = 1'b1;
            if (!vc_tag_write && vc_tag_store_ld_mask !== 8'h00) r_bad = 1'b1;
            if (vc_tag_write && !$onehot(vc_tag_store_ld_mask)) r_bad = 1'b1;
            if (r_lat > 1 && vc_tag_cmp) r_bad = 1'b1;
            if (vc_tag_write) begin r_mask = vc_tag_store_ld_mask; r_wtag = vc_tag_store_datain; end
            if (mem_wb_req) begin
                if (r_wbc > 0 && vc_wb_sel !== r_wbs) r_bad = 1'b1;
                r_wbc++;
                r_wbs = vc_wb_sel;
            end
            mem_wb_ack = mem_wb_req && (r_wbc == ack_at);
            tick();
            r_lat++;
        end
        mem_wb_ack = 1'b0;
        r_hit = vc_l1_hit;
        got = {8'(r_lat), r_hit, r_mask};
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        checks++; if (all_outs() !== 53'd0) $display("FAIL reset_outs: got %0h expected 0", all_outs()); else passed++;
        rst = 1'b1;
        tick();
        checks++; if (all_outs() !== 53'd0) $display("FAIL idle_outs: got %0h expected 0", all_outs()); else passed++;
    endtask

    task automatic test_miss_no_victim();
        run_req(24'h000000, 1'b0, 24'h0, 1'b0, 4'd0, 0);
        checks++; if ({r_cmp, r_din} !== {1'b1, 24'h0}) $display("FAIL miss0_cmp: got %0h expected 1000000", {r_cmp, r_din}); else passed++;
        checks++; if (got !== {8'd2, 1'b0, 8'h00}) $display("FAIL miss0_resp: got %0h expected %0h", got, {8'd2, 1'b0, 8'h00}); else passed++;
        run_req(24'h123456, 1'b0, 24'h0, 1'b0, 4'd9, 0);
        checks++; if ({r_cmp, r_din, got} !== {1'b1, 24'h123456, 8'd2, 1'b0, 8'h00}) $display("FAIL miss_tag: got %0h/%0h expected 123456/%0h", r_din, got, {8'd2, 1'b0, 8'h00}); else passed++;
    endtask

    task automatic test_insert_empty();
        run_req(24'h1, 1'b1, 24'hA, 1'b0, 4'd8, 0);
        checks++; if (got !== {8'd3, 1'b0, 8'h01}) $display("FAIL insert_empty: got %0h expected %0h", got, {8'd3, 1'b0, 8'h01}); else passed++;
        checks++; if ({r_wtag, r_wbc[3:0], r_bad} !== {24'hA, 4'd0, 1'b0}) $display("FAIL insert_empty_wr: got tag %0h wb %0d bad %0b expected a/0/0", r_wtag, r_wbc, r_bad); else passed++;
    endtask

    task automatic test_fill();
        for (int i = 1; i < 8; i++) begin
            run_req(24'h100 + 24'(i), 1'b1, 24'hA + 24'(i), 1'b0, 4'd15, 0);
            checks++; if ({got, r_bad} !== {8'd3, 1'b0, 8'(1 << i), 1'b0}) $display("FAIL fill_%0d: got %0h bad %0b expected %0h", i, got, r_bad, {8'd3, 1'b0, 8'(1 << i)}); else passed++;
        end
    endtask

    task automatic test_swap();
        run_req(24'h300, 1'b1, 24'h55, 1'b0, 4'd3, 0);
        checks++; if ({got, r_wtag, r_bad} !== {8'd3, 1'b1, 8'h08, 24'h55, 1'b0}) $display("FAIL swap3: got %0h tag %0h bad %0b expected %0h tag 55", got, r_wtag, r_bad, {8'd3, 1'b1, 8'h08}); else passed++;
        run_req(24'h301, 1'b1, 24'h66, 1'b1, 4'd0, 0);
        checks++; if (got !== {8'd3, 1'b1, 8'h01}) $display("FAIL swap0_dirty: got %0h expected %0h", got, {8'd3, 1'b1, 8'h01}); else passed++;
    endtask

    task automatic test_invalidate();
        run_req(24'h500, 1'b0, 24'h0, 1'b0, 4'd5, 0);
        checks++; if (got !== {8'd3, 1'b1, 8'h00}) $display("FAIL swap_novictim: got %0h expected %0h", got, {8'd3, 1'b1, 8'h00}); else passed++;
        run_req(24'h500, 1'b0, 24'h0, 1'b0, 4'd5, 0);
        checks++; if (got !== {8'd2, 1'b0, 8'h00}) $display("FAIL hit_invalid: got %0h expected %0h", got, {8'd2, 1'b0, 8'h00}); else passed++;
        run_req(24'h501, 1'b1, 24'h88, 1'b0, 4'd15, 0);
        checks++; if ({got, r_wbc[3:0]} !== {8'd3, 1'b0, 8'h20, 4'd0}) $display("FAIL refill5: got %0h wb %0d expected %0h wb 0", got, r_wbc, {8'd3, 1'b0, 8'h20}); else passed++;
    endtask

    task automatic test_writeback();
        run_req(24'h700, 1'b1, 24'h77, 1'b0, 4'd15, 5);
        checks++; if ({r_wbc[3:0], r_wbs, r_bad} !== {4'd5, 4'd0, 1'b0}) $display("FAIL wb_req: got cycles %0d sel %0d bad %0b expected 5/0/0", r_wbc, r_wbs, r_bad); else passed++;
        checks++; if ({got, r_wtag} !== {8'd8, 1'b0, 8'h01, 24'h77}) $display("FAIL wb_insert: got %0h tag %0h expected %0h tag 77", got, r_wtag, {8'd8, 1'b0, 8'h01}); else passed++;
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 8; i++) begin
            run_req(24'h900, 1'b1, 24'h900 + 24'(i), 1'b0, 4'd15, 0);
            checks++; if ({got, r_wbc[3:0]} !== {8'd3, 1'b0, 8'(1 << (i % 8)), 4'd0}) $display("FAIL wrap_%0d: got %0h wb %0d expected %0h", i, got, r_wbc, {8'd3, 1'b0, 8'(1 << (i % 8))}); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int resp_cnt = 0;
        l1_vc_req = 1'b1; l1_vc_tag = 24'hBEEF; l1_victim_valid = 1'b0; vc_datamux_sel = 4'd15;
        tick();
        checks++; if (vc_busy !== 1'b1) $display("FAIL busy_cmp: got %0b expected 1", vc_busy); else passed++;
        for (int c = 1; c <= 10; c++) begin
            if (c == 3) l1_vc_req = 1'b0;
            if (vc_l1_resp) resp_cnt++;
            tick();
        end
        checks++; if ({resp_cnt[3:0], vc_busy} !== {4'd1, 1'b0}) $display("FAIL busy_ignore: got resps %0d busy %0b expected 1/0", resp_cnt, vc_busy); else passed++;
    endtask

    task automatic test_reset_in_wb();
        logic stray = 1'b0;
        run_req(24'hA00, 1'b1, 24'hAA, 1'b1, 4'd1, 0);
        checks++; if (got !== {8'd3, 1'b1, 8'h02}) $display("FAIL swap1_dirty: got %0h expected %0h", got, {8'd3, 1'b1, 8'h02}); else passed++;
        l1_vc_req = 1'b1; l1_victim_valid = 1'b1; l1_victim_tag = 24'hBB; l1_victim_dirty = 1'b0; vc_datamux_sel = 4'd15;
        tick();
        l1_vc_req = 1'b0;
        tick();
        checks++; if ({mem_wb_req, vc_wb_sel} !== {1'b1, 4'd1}) $display("FAIL wb_before_rst: got %0h expected 11", {mem_wb_req, vc_wb_sel}); else passed++;
        rst = 1'b0;
        #1;
        checks++; if (all_outs() !== 53'd0) $display("FAIL rst_in_wb: got %0h expected 0", all_outs()); else passed++;
        repeat (2) tick();
        rst = 1'b1;
        mem_wb_ack = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (vc_l1_resp || vc_tag_write || vc_data_write || mem_wb_req || vc_busy) stray = 1'b1;
            tick();
        end
        mem_wb_ack = 1'b0;
        checks++; if (stray !== 1'b0) $display("FAIL rst_abandon: got activity %0b expected 0", stray); else passed++;
        run_req(24'hC00, 1'b0, 24'h0, 1'b0, 4'd2, 0);
        checks++; if (got !== {8'd2, 1'b0, 8'h00}) $display("FAIL rst_cleared_valid: got %0h expected %0h", got, {8'd2, 1'b0, 8'h00}); else passed++;
        run_req(24'hC01, 1'b1, 24'hCC, 1'b0, 4'd15, 0);
        checks++; if (got !== {8'd3, 1'b0, 8'h01}) $display("FAIL rst_insert0: got %0h expected %0h", got, {8'd3, 1'b0, 8'h01}); else passed++;
    endtask

    initial begin
        test_reset();
        test_miss_no_victim();
        test_insert_empty();
        test_fill();
        test_swap();
        test_invalidate();
        test_writeback();
        test_wrap();
        test_back_to_back();
        test_reset_in_wb();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
